adc_lane_router: RTL and testbench
==================================

Name: adc_lane_router

Overview:
- Sits directly upstream of the 1:2 sample demux stage in the MAX10 ADC firmware.
- Takes the free-running ADC sample stream and steers each sample to one of two lanes.
- Steering is either ping-pong (even/odd interleave) or driven by an external select.
- Each lane has a small FIFO so per-lane consumers can apply valid/ready backpressure. Overflow is counted, never stalls the ADC.

Parameters:
WIDTH, 8, ADC sample width in bits
DEPTH, 4, per-lane FIFO depth in entries (power of 2, >=2)
CNTW, 16, drop counter width

Ports:
clk  input  1  system clock; all logic rising-edge
rstn  input  1  asynchronous active-low reset
in_data  input  WIDTH  ADC sample
in_valid  input  1  sample present this cycle; no input backpressure
mode  input  1  0 = ping-pong steering, 1 = steer by sel
sel  input  1  target lane when mode=1 (0 -> lane0, 1 -> lane1)
clear  input  1  synchronous flush: empties both FIFOs, toggle=0, drop_count=0
out0_data  output  WIDTH  lane0 head sample
out0_valid  output  1  lane0 FIFO not empty
out0_ready  input  1  lane0 consumer accepts head
out1_data  output  WIDTH  lane1 head sample
out1_valid  output  1  lane1 FIFO not empty
out1_ready  input  1  lane1 consumer accepts head
lane_next  output  1  lane the next ping-pong sample targets
drop_count  output  CNTW  saturating count of dropped samples

Behaviour:
- Reset (rstn low, async): FIFOs empty; outN_valid=0, outN_data=0, lane_next=0, drop_count=0. Release takes effect at the next clk edge.
- Target lane for an accepted sample is `mode ? sel : lane_next`.
- Toggle:
  - Flips on every in_valid cycle when mode=0, including dropped samples, so lane phase stays locked to sample parity.
  - Holds when mode=1.
  - A mode change takes effect on the same cycle; toggle is not reset by it.
- Push: on an in_valid cycle the sample is written to the target FIFO tail, unless it is full and not being popped that same cycle.
- Full and popped on the same cycle: push and pop both occur; occupancy is unchanged; no drop.
- Drop: target FIFO full with no same-cycle pop.
  - Sample is discarded and drop_count increments by 1.
  - drop_count saturates at 2^CNTW-1, with no wrap.
  - The other lane is unaffected.
- Output (show-ahead):
  - outN_valid = occupancy != 0, and outN_data = head entry, both registered.
  - Pop when outN_valid && outN_ready.
  - outN_ready while outN_valid=0 has no effect.
  - outN_data holds its last value when the FIFO is empty; the consumer must ignore it.
- Latency: a sample pushed into an empty FIFO at edge N is visible on outN_valid/outN_data after edge N, i.e. one cycle.
- Pop with simultaneous push on a FIFO with one entry: valid stays 1 and data advances to the new sample.
- Pointer wrap: read/write pointers are log2(DEPTH)+1 bits. Full means MSBs differ and LSBs are equal; empty means the pointers are equal. Wrap is seamless and must show no data reorder across the DEPTH boundary.
- Order is preserved per lane. Both lanes operate independently and concurrently.
- clear:
  - Has priority over push, pop and drop in that cycle; the sample presented that cycle is discarded and not counted.
  - Next cycle: outN_valid=0, lane_next=0, drop_count=0.
- Reset asserted mid-stream: all state is lost immediately (async), with no partial output.

Test Plan:
- mode=0, both readies=1, in_valid continuous with samples 0x10,0x11,0x12,0x13 -> lane0 gets 0x10,0x12; lane1 gets 0x11,0x13; each appears 1 cycle after input; drop_count=0.
- mode=1, sel=1, out1_ready=0, 6 samples 0xA0..0xA5 -> lane1 holds 0xA0..0xA3, drop_count=2, out0_valid=0. Then out1_ready=1 -> 0xA0,0xA1,0xA2,0xA3 in order, then out1_valid=0.
- Lane1 full (DEPTH=4), with out1_ready=1 and a new sample to lane1 in the same cycle -> no drop, occupancy stays 4, new sample emerges last.
- Run 13 samples through lane0 with random out0_ready -> output order equals input order; scoreboard matches across pointer wrap.
- drop_count preloaded to 0xFFFE by forcing drops, then 3 more drops -> saturates at 0xFFFF. Then assert clear with in_valid=1 -> next cycle drop_count=0, both out valid=0, lane_next=0, and the cleared-cycle sample is absent.
- Assert rstn=0 asynchronously between edges with both FIFOs half full -> outputs go to 0 immediately. After release, the first sample in mode=0 goes to lane0.

Source files
------------

// File: rtl/adc_lane_router.sv
// adc_lane_router: steers a free-running ADC sample stream into two
// show-ahead lane FIFOs, either ping-pong (even/odd interleave) or by an
// external select. A full lane drops the sample and bumps a saturating
// drop counter; the ADC side is never stalled.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   in_data, in_valid    ADC sample stream (no backpressure)
//   mode, sel            0: ping-pong on lane_next, 1: steer to lane sel
//   clear                synchronous flush of FIFOs, toggle and drop count
//   outN_data/valid/ready  per-lane valid/ready consumer interface (N=0,1)
//   lane_next            lane the next ping-pong sample targets
//   drop_count           saturating count of dropped samples
module adc_lane_router #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNTW  = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             mode,
  input  logic             sel,
  input  logic             clear,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic             lane_next,
  output logic [CNTW-1:0]  drop_count
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned LANES = 2;

  logic [WIDTH-1:0] mem_q   [LANES][DEPTH];
  logic [WIDTH-1:0] mem_d   [LANES][DEPTH];
  logic [PW-1:0]    wptr_q  [LANES];
  logic [PW-1:0]    wptr_d  [LANES];
  logic [PW-1:0]    rptr_q  [LANES];
  logic [PW-1:0]    rptr_d  [LANES];
  logic [WIDTH-1:0] data_q  [LANES];
  logic [WIDTH-1:0] data_d  [LANES];
  logic [LANES-1:0] valid_q;
  logic [LANES-1:0] valid_d;
  logic             toggle_q;
  logic             toggle_d;
  logic [CNTW-1:0]  drop_q;
  logic [CNTW-1:0]  drop_d;

  logic [LANES-1:0] ready_c;
  logic [LANES-1:0] pop_c;
  logic [LANES-1:0] full_c;
  logic [LANES-1:0] hit_c;
  logic             target_c;
  logic             drop_c;

  assign ready_c  = {out1_ready, out0_ready};
  assign target_c = mode ? sel : toggle_q;

  // Next-state for both lanes, toggle and drop counter
  always_comb begin
    mem_d    = mem_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    data_d   = data_q;
    valid_d  = valid_q;
    toggle_d = toggle_q;
    drop_d   = drop_q;
    pop_c    = '0;
    full_c   = '0;
    hit_c    = '0;
    drop_c   = 1'b0;

    // Toggle follows sample parity in ping-pong mode, dropped samples included
    if (in_valid && !mode) begin
      toggle_d = ~toggle_q;
    end

    for (int l = 0; l < LANES; l++) begin
      pop_c[l]  = valid_q[l] & ready_c[l];
      full_c[l] = (wptr_q[l][AW] != rptr_q[l][AW]) &&
                  (wptr_q[l][AW-1:0] == rptr_q[l][AW-1:0]);
      hit_c[l]  = in_valid && (target_c == 1'(l));

      // A same-cycle pop frees the slot the push lands in, so full+pop is no drop
      if (hit_c[l]) begin
        if (!full_c[l] || pop_c[l]) begin
          mem_d[l][wptr_q[l][AW-1:0]] = in_data;
          wptr_d[l] = wptr_q[l] + PW'(1);
        end else begin
          drop_c = 1'b1;
        end
      end

      if (pop_c[l]) begin
        rptr_d[l] = rptr_q[l] + PW'(1);
      end
    end

    if (drop_c && (drop_q != '1)) begin
      drop_d = drop_q + CNTW'(1);
    end

    // Flush wins over everything in the same cycle
    if (clear) begin
      for (int l = 0; l < LANES; l++) begin
        wptr_d[l] = '0;
        rptr_d[l] = '0;
      end
      toggle_d = 1'b0;
      drop_d   = '0;
    end

    // Show-ahead head register; data holds while the lane is empty
    for (int l = 0; l < LANES; l++) begin
      valid_d[l] = (wptr_d[l] != rptr_d[l]);
      if (valid_d[l]) begin
        data_d[l] = mem_d[l][rptr_d[l][AW-1:0]];
      end
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int l = 0; l < LANES; l++) begin
        wptr_q[l] <= '0;
        rptr_q[l] <= '0;
        data_q[l] <= '0;
      end
      valid_q  <= '0;
      toggle_q <= 1'b0;
      drop_q   <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      toggle_q <= toggle_d;
      drop_q   <= drop_d;
    end
  end

  // Storage array; contents are don't-care while pointers say empty
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out0_data  = data_q[0];
  assign out0_valid = valid_q[0];
  assign out1_data  = data_q[1];
  assign out1_valid = valid_q[1];
  assign lane_next  = toggle_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_adc_lane_router.sv
// Directed bench for adc_lane_router: ping-pong split, select steering with
// drops, full+pop, lane0 order across pointer wrap, drop saturation, clear
// and asynchronous reset.
module tb_adc_lane_router;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNTW  = 16;

  logic             clk = 1'b0;
  logic             rstn;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             mode;
  logic             sel;
  logic             clear;
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;
  logic             lane_next;
  logic [CNTW-1:0]  drop_count;

  int tests = 0;
  int fails = 0;

  adc_lane_router #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .mode       (mode),
    .sel        (sel),
    .clear      (clear),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .lane_next  (lane_next),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] q[$];
  int               sent;
  int               exp_drop;
  int               cyc;
  logic             iv;
  logic             rdy;
  logic             pop;
  int               sz;

  initial begin
    rstn = 1'b0; in_data = '0; in_valid = 1'b0; mode = 1'b0; sel = 1'b0;
    clear = 1'b0; out0_ready = 1'b0; out1_ready = 1'b0;
    #12;
    // Reset state
    chk("rst_o0v", 32'(out0_valid), 0);
    chk("rst_o1v", 32'(out1_valid), 0);
    chk("rst_o0d", 32'(out0_data), 0);
    chk("rst_o1d", 32'(out1_data), 0);
    chk("rst_lane", 32'(lane_next), 0);
    chk("rst_drop", 32'(drop_count), 0);
    rstn = 1'b1;

    // 1: ping-pong with both consumers ready
    mode = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h10;
    step();
    chk("pp0_o0v", 32'(out0_valid), 1); chk("pp0_o0d", 32'(out0_data), 32'h10);
    chk("pp0_o1v", 32'(out1_valid), 0); chk("pp0_lane", 32'(lane_next), 1);
    in_data = 8'h11;
    step();
    chk("pp1_o0v", 32'(out0_valid), 0); chk("pp1_o1v", 32'(out1_valid), 1);
    chk("pp1_o1d", 32'(out1_data), 32'h11);
    in_data = 8'h12;
    step();
    chk("pp2_o0v", 32'(out0_valid), 1); chk("pp2_o0d", 32'(out0_data), 32'h12);
    chk("pp2_o1v", 32'(out1_valid), 0);
    in_data = 8'h13;
    step();
    chk("pp3_o1v", 32'(out1_valid), 1); chk("pp3_o1d", 32'(out1_data), 32'h13);
    chk("pp3_o0v", 32'(out0_valid), 0);
    in_valid = 1'b0;
    step();
    chk("pp4_o0v", 32'(out0_valid), 0); chk("pp4_o1v", 32'(out1_valid), 0);
    chk("pp4_drop", 32'(drop_count), 0); chk("pp4_lane", 32'(lane_next), 0);

    // 2: select lane1, consumer stalled, overflow by two
    mode = 1'b1; sel = 1'b1; out1_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 8'(8'hA0 + i);
      step();
    end
    in_valid = 1'b0;
    chk("sel_o1v", 32'(out1_valid), 1); chk("sel_o1d", 32'(out1_data), 32'hA0);
    chk("sel_drop", 32'(drop_count), 2); chk("sel_o0v", 32'(out0_valid), 0);
    chk("sel_lane", 32'(lane_next), 0);
    out1_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      chk("sel_drain_v", 32'(out1_valid), 1);
      chk("sel_drain_d", 32'(out1_data), 32'(8'hA0 + i));
    end
    step();
    chk("sel_empty", 32'(out1_valid), 0);
    chk("sel_hold_d", 32'(out1_data), 32'hA3);

    // 3: lane1 full, pop and push on the same edge
    out1_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'(8'hB0 + i);
      step();
    end
    in_data = 8'hB4; out1_ready = 1'b1;
    step();
    chk("fp_o1v", 32'(out1_valid), 1); chk("fp_o1d", 32'(out1_data), 32'hB1);
    chk("fp_drop", 32'(drop_count), 2);
    // Still full: one more sample with no pop must drop
    out1_ready = 1'b0; in_data = 8'hB5;
    step();
    chk("fp_full_drop", 32'(drop_count), 3);
    in_valid = 1'b0; out1_ready = 1'b1;
    chk("fp_head", 32'(out1_data), 32'hB1);
    for (int i = 2; i < 5; i++) begin
      step();
      chk("fp_drain_d", 32'(out1_data), 32'(8'hB0 + i));
    end
    step();
    chk("fp_empty", 32'(out1_valid), 0);

    // 4: lane0 scoreboard with random ready across pointer wrap
    mode = 1'b1; sel = 1'b0;
    sent = 0; exp_drop = 0; cyc = 0;
    q.delete();
    while ((sent < 13 || q.size() > 0) && cyc < 300) begin
      iv  = (sent < 13) && ($urandom_range(0, 3) != 0);
      rdy = 1'($urandom_range(0, 1));
      in_valid = iv; in_data = 8'(8'h40 + sent); out0_ready = rdy;
      sz  = q.size();
      pop = (sz > 0) && rdy;
      if (pop) void'(q.pop_front());
      if (iv) begin
        if (sz < int'(DEPTH) || pop) q.push_back(8'(8'h40 + sent));
        else exp_drop++;
        sent++;
      end
      step();
      cyc++;
      chk("sb_v", 32'(out0_valid), 32'(q.size() > 0));
      if (q.size() > 0) chk("sb_d", 32'(out0_data), 32'(q[0]));
    end
    in_valid = 1'b0;
    chk("sb_budget", 32'(cyc < 300), 1);
    chk("sb_drop", 32'(drop_count), 32'(3 + exp_drop));

    // 5: drop counter saturation then clear
    clear = 1'b1;
    step();
    clear = 1'b0;
    mode = 1'b1; sel = 1'b1; out1_ready = 1'b0; out0_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(8'hC0 + i);
      step();
    end
    for (int i = 0; i < 65534; i++) begin
      in_data = 8'hEE;
      step();
    end
    chk("sat_fffe", 32'(drop_count), 32'hFFFE);
    for (int i = 0; i < 3; i++) step();
    chk("sat_ffff", 32'(drop_count), 32'hFFFF);
    chk("sat_o1d", 32'(out1_data), 32'hC0);
    mode = 1'b0; in_data = 8'h55;
    step();
    chk("sat_lane", 32'(lane_next), 1); chk("sat_o0v", 32'(out0_valid), 1);
    chk("sat_hold", 32'(drop_count), 32'hFFFF);
    clear = 1'b1; in_data = 8'h77;
    step();
    clear = 1'b0; in_valid = 1'b0;
    chk("clr_drop", 32'(drop_count), 0); chk("clr_o0v", 32'(out0_valid), 0);
    chk("clr_o1v", 32'(out1_valid), 0); chk("clr_lane", 32'(lane_next), 0);
    step();
    chk("clr_absent0", 32'(out0_valid), 0); chk("clr_absent1", 32'(out1_valid), 0);

    // 6: asynchronous reset with both lanes half full
    mode = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(8'hD0 + i);
      step();
    end
    in_valid = 1'b0;
    chk("pre_o0d", 32'(out0_data), 32'hD0); chk("pre_o1d", 32'(out1_data), 32'hD1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_o0v", 32'(out0_valid), 0); chk("arst_o1v", 32'(out1_valid), 0);
    chk("arst_o0d", 32'(out0_data), 0);  chk("arst_o1d", 32'(out1_data), 0);
    chk("arst_drop", 32'(drop_count), 0);
    #2 rstn = 1'b1;
    out0_ready = 1'b1; out1_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'hE0;
    step();
    in_valid = 1'b0;
    chk("post_o0v", 32'(out0_valid), 1); chk("post_o0d", 32'(out0_data), 32'hE0);
    chk("post_o1v", 32'(out1_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
